seg7_multi_disp: RTL and testbench
==================================

// Module: seg7_multi_disp
// PURPOSE
//  Registered N-digit 7-segment display driver for the DE1-SoC HEX0..HEX5 static displays.
//  Captures a binary value on a load strobe and shows it in hex or decimal.
//  Decimal mode uses a sequential double-dabble converter with a busy handshake.
//  Supports leading-zero blanking and overflow indication.
//  Sits between application status registers and the board HEX pins; it replaces per-digit combinational encoders.
// PARAMETERS
//  NDIGITS    6           number of displayed digits (1..8)
//  DATA_W     20          width of din (1..32)
//  BLINK_DIV  25000000    clk cycles per blink half-period (used only with SEG_BLINK_EN)
// PORTS
//  clk       in   1            single system clock, rising edge
//  rst       in   1            synchronous, active-high reset
//  din       in   DATA_W       value to display, unsigned
//  dec_mode  in   1            1 = decimal, 0 = hex; sampled with load
//  lz_blank  in   1            1 = blank leading zeros; sampled with load
//  load      in   1            capture din/dec_mode/lz_blank; honoured only when busy=0
//  busy      out  1            decimal conversion in progress
//  ovf       out  1            last committed value did not fit in NDIGITS digits
//  leds      out  7*NDIGITS    active-low segments; digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}; digit 0 = least significant
//  blink     in   NDIGITS      per-digit blink mask (port exists only with SEG_BLINK_EN)
// BEHAVIOUR
//  - Reset: leds all ones (all digits dark), busy=0, ovf=0, FSM=IDLE, blink counter/phase=0.
//    rst in any state, including mid-conversion, aborts the conversion and returns to this state.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE -load&dec_mode-> SHIFT.
//    SHIFT (exactly DATA_W cycles) -> DONE.
//    DONE (1 cycle) -> IDLE.
//  - Hex load (load at edge 0, dec_mode=0):
//    * digits = din zero-extended/truncated to 4*NDIGITS bits.
//    * ovf=1 if any din bit above 4*NDIGITS-1 is set.
//    * leds/ovf updated at edge 1; busy stays 0.
//  - Decimal load (load at edge 0, dec_mode=1):
//    * busy=1 after edge 0.
//    * Edges 1..DATA_W: one double-dabble step each, MSB first. Per step: add 3 to every BCD digit >=5, then shift left 1 with the next din bit entering digit 0 bit 0.
//    * Any 1 shifted out of digit NDIGITS-1 sets an internal overflow flag.
//    * Edge DATA_W+1 (DONE): leds and ovf committed, busy=0.
//    * Total latency DATA_W+1 cycles.
//  - load while busy=1, including the DONE cycle, is ignored; din may change freely while busy.
//  - leds change only on commit and on blink phase; no glitches between commits.
//  - Encoding, 0..F (active-low {g..a}):
//    0=1000000  1=1111001  2=0100100  3=0110000
//    4=0011001  5=0010010  6=0000010  7=1111000
//    8=0000000  9=0010000  A=0001000  b=0000011
//    C=1000110  d=0100001  E=0000110  F=0001110
//    blank=1111111   dash=0111111
//  - Overflow: when ovf=1, every digit shows dash; lz_blank has no effect.
//  - Leading-zero blanking (lz_blank=1, ovf=0): every digit above the most significant non-zero digit shows blank.
//    Digit 0 is always shown, so value 0 shows a single "0".
// CONFIGURATION
//  SEG_BLINK_EN defined:
//    * adds the blink port and a free-running counter 0..BLINK_DIV-1.
//    * phase toggles on each wrap.
//    * while phase=1, digits with blink[k]=1 show blank; all other digits are unaffected.
//    * blink is sampled every cycle and is not latched by load.
//  SEG_BLINK_EN undefined: no blink port, no counter; BLINK_DIV unused; leds depend on commits only.
// TESTING (NDIGITS=6, DATA_W=20)
//  1. Hold rst 2 cycles -> leds=42'h3FF_FFFF_FFFF, busy=0, ovf=0; stays dark with no load.
//  2. Hex load din=20'hA5F03, lz_blank=0 -> after 1 edge, digits[5..0] = 0,A,5,F,0,3;
//     digit0=0110000, digit5=1000000; busy never 1.
//  3. Decimal load din=20'd123456 -> busy=1 for exactly 21 cycles; then digits[5..0] = 1..6, ovf=0.
//  4. Decimal load din=20'd1000000 -> after commit ovf=1, all six digits = 0111111.
//     Then decimal load 20'd42, lz_blank=1 -> digits[5..2] = 1111111, digit1=0011001, digit0=0100100, ovf=0.
//  5. Pulse load with 20'd7 at busy cycle 5 of a 20'd999999 conversion -> ignored, shows 999999.
//     Assert rst mid-conversion -> immediate dark leds, busy=0; next load converts correctly.
//  6. (SEG_BLINK_EN, BLINK_DIV=4) blink=6'b000001 on value 12 -> digit0 alternates 0100100 / 1111111 every 4 cycles; digit1 steady.

Source files
------------

// File: rtl/seg7_multi_disp.sv
// seg7_multi_disp: registered N-digit 7-segment driver for the DE1-SoC HEX displays.
// Captures a binary value on load and shows it in hex, or in decimal via a
// sequential double-dabble converter (busy high while converting). Supports
// leading-zero blanking and an overflow indication (all digits show a dash).
// Optional feature macro: SEG_BLINK_EN adds the per-digit blink port and the
// free-running blink-phase counter.
module seg7_multi_disp #(
    parameter int NDIGITS   = 6,
    parameter int DATA_W    = 20,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      din,
    input  logic                   dec_mode,
    input  logic                   lz_blank,
    input  logic                   load,
`ifdef SEG_BLINK_EN
    input  logic [NDIGITS-1:0]     blink,
`endif
    output logic                   busy,
    output logic                   ovf,
    output logic [7*NDIGITS-1:0]   leds
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BCD_W-1:0]     bcd_q;
    logic [DATA_W-1:0]    src_q;
    logic [CNT_W-1:0]     stepCnt_q;
    logic                 ovfAcc_q;
    logic                 lz_q;
    logic                 hexPend_q;
    logic [7*NDIGITS-1:0] segs_q;
    logic                 ovf_q;

    logic                 loadAccept;
    logic                 commit;
    logic [EXT_W-1:0]     dinExt;
    logic [BCD_W-1:0]     hexDigits;
    logic                 hexOvf;
    logic [BCD_W-1:0]     adjusted;
    logic [BCD_W-1:0]     shifted;
    logic                 shiftOut;
    logic [7*NDIGITS-1:0] segsNext;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] encodeHex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // A load is only taken while idle; loads during SHIFT or DONE are dropped.
    assign loadAccept = load && (state_q == IDLE);

    // Commit happens one edge after a hex load, or in the DONE cycle of a conversion.
    assign commit = hexPend_q || (state_q == DONE);

    // Hex path: widen din so truncation and the overflow test work for any DATA_W.
    assign dinExt    = EXT_W'(din);
    assign hexDigits = dinExt[BCD_W-1:0];
    assign hexOvf    = |(dinExt >> BCD_W);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: SHIFT lasts exactly DATA_W cycles, DONE one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (loadAccept && dec_mode) state_d = SHIFT;
            SHIFT:   if (stepCnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy covers SHIFT and the DONE commit cycle.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // One double-dabble step: add 3 to digits >= 5, then shift in the next source bit.
    always_comb begin
        adjusted = bcd_q;
        for (int k = 0; k < NDIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        shifted  = {adjusted[BCD_W-2:0], src_q[DATA_W-1]};
        shiftOut = adjusted[BCD_W-1];
    end

    // Segment image for the pending value: dashes on overflow, else optional blanking above the top non-zero digit.
    always_comb begin
        logic       lead;
        logic [3:0] digit;
        segsNext = '1;
        lead     = lz_q;
        digit    = 4'd0;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            digit = bcd_q[4*k +: 4];
            if ((digit != 4'd0) || (k == 0)) begin
                lead = 1'b0;
            end
            if (ovfAcc_q) begin
                segsNext[7*k +: 7] = 7'b0111111;
            end else if (lead) begin
                segsNext[7*k +: 7] = 7'b1111111;
            end else begin
                segsNext[7*k +: 7] = encodeHex(digit);
            end
        end
    end

    // Datapath: capture on load, run conversion steps, and commit the display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q     <= '0;
            src_q     <= '0;
            stepCnt_q <= '0;
            ovfAcc_q  <= 1'b0;
            lz_q      <= 1'b0;
            hexPend_q <= 1'b0;
            segs_q    <= '1;
            ovf_q     <= 1'b0;
        end else begin
            hexPend_q <= 1'b0;
            if (commit) begin
                segs_q <= segsNext;
                ovf_q  <= ovfAcc_q;
            end
            if (loadAccept) begin
                lz_q <= lz_blank;
                if (dec_mode) begin
                    bcd_q     <= '0;
                    src_q     <= din;
                    stepCnt_q <= '0;
                    ovfAcc_q  <= 1'b0;
                end else begin
                    bcd_q     <= hexDigits;
                    ovfAcc_q  <= hexOvf;
                    hexPend_q <= 1'b1;
                end
            end else if (state_q == SHIFT) begin
                bcd_q     <= shifted;
                src_q     <= src_q << 1;
                stepCnt_q <= stepCnt_q + 1'b1;
                if (shiftOut) begin
                    ovfAcc_q <= 1'b1;
                end
            end
        end
    end

    assign ovf = ovf_q;

`ifdef SEG_BLINK_EN
    localparam int BLINK_CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_CW-1:0] blinkCnt_q;
    logic                phase_q;

    // Free-running blink counter; the phase flips every time it wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            blinkCnt_q <= '0;
            phase_q    <= 1'b0;
        end else if (blinkCnt_q == BLINK_CW'(BLINK_DIV - 1)) begin
            blinkCnt_q <= '0;
            phase_q    <= ~phase_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + 1'b1;
        end
    end

    // Blank the masked digits during the blink-off phase; others pass the committed image.
    always_comb begin
        leds = segs_q;
        for (int k = 0; k < NDIGITS; k++) begin
            if (phase_q && blink[k]) begin
                leds[7*k +: 7] = 7'b1111111;
            end
        end
    end
`else
    assign leds = segs_q;
`endif

endmodule

// File: tb/tb_seg7_multi_disp.sv
// tb_seg7_multi_disp: table-driven bench for seg7_multi_disp (NDIGITS=6, DATA_W=20).
// Blink checks are compiled in when SEG_BLINK_EN is defined (BLINK_DIV=4).
module tb_seg7_multi_disp;

   localparam int NDIGITS = 6;
   localparam int DATA_W  = 20;

   localparam logic [6:0] S0  = 7'b1000000;
   localparam logic [6:0] S1  = 7'b1111001;
   localparam logic [6:0] S2  = 7'b0100100;
   localparam logic [6:0] S3  = 7'b0110000;
   localparam logic [6:0] S4  = 7'b0011001;
   localparam logic [6:0] S5  = 7'b0010010;
   localparam logic [6:0] S6  = 7'b0000010;
   localparam logic [6:0] S9  = 7'b0010000;
   localparam logic [6:0] SA  = 7'b0001000;
   localparam logic [6:0] SF  = 7'b0001110;
   localparam logic [6:0] BLK = 7'b1111111;
   localparam logic [6:0] DSH = 7'b0111111;
   localparam logic [41:0] DARK = {42{1'b1}};

   typedef struct {
      string       name;
      logic [19:0] din;
      logic        decMode;
      logic        lzBlank;
      logic [41:0] expLeds;
      logic        expOvf;
      int          expBusy;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [DATA_W-1:0]    din = '0;
   logic                 decMode = 1'b0;
   logic                 lzBlank = 1'b0;
   logic                 load = 1'b0;
   logic                 busy;
   logic                 ovf;
   logic [7*NDIGITS-1:0] leds;
`ifdef SEG_BLINK_EN
   logic [NDIGITS-1:0]   blink = '0;
`endif

   int          nChecks = 0;
   int          nFail = 0;
   logic [41:0] prevExp = DARK;
   vec_t        vecs[11];

   seg7_multi_disp #(
      .NDIGITS(NDIGITS),
      .DATA_W(DATA_W),
      .BLINK_DIV(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .dec_mode(decMode),
      .lz_blank(lzBlank),
      .load(load),
`ifdef SEG_BLINK_EN
      .blink(blink),
`endif
      .busy(busy),
      .ovf(ovf),
      .leds(leds)
   );

   // 10 ns clock period
   always #5 clk = ~clk;

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required earlier finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value with its expected value and keep the tallies
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one load, track busy and display stability, then check the committed result
   task automatic applyStimulus(input vec_t v);
      int   busyCycles;
      logic holdOk;
      @(negedge clk);
      din     = v.din;
      decMode = v.decMode;
      lzBlank = v.lzBlank;
      load    = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      busyCycles = 0;
      holdOk = (leds === prevExp);
      while (busy === 1'b1 && busyCycles < 100) begin
         busyCycles++;
         din     = 20'($urandom);
         decMode = 1'($urandom_range(0, 1));
         lzBlank = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (busy === 1'b1 && leds !== prevExp) holdOk = 1'b0;
      end
      if (busyCycles == 0) begin
         @(posedge clk);
         #1;
      end
      checkOutput({v.name, " busy cycles"}, 64'(busyCycles), 64'(v.expBusy));
      checkOutput({v.name, " hold"}, 64'(holdOk), 64'd1);
      checkOutput({v.name, " leds"}, 64'(leds), 64'(v.expLeds));
      checkOutput({v.name, " ovf"}, 64'(ovf), 64'(v.expOvf));
      prevExp = v.expLeds;
   endtask

   initial begin
      int   cyc;
      logic [41:0] expC;
      vecs[0]  = '{"hexA5F03",  20'hA5F03,   1'b0, 1'b0, {S0, SA, S5, SF, S0, S3},     1'b0, 0};
      vecs[1]  = '{"dec123456", 20'd123456,  1'b1, 1'b0, {S1, S2, S3, S4, S5, S6},     1'b0, 21};
      vecs[2]  = '{"dec1000000",20'd1000000, 1'b1, 1'b1, {DSH, DSH, DSH, DSH, DSH, DSH}, 1'b1, 21};
      vecs[3]  = '{"dec42lz",   20'd42,      1'b1, 1'b1, {BLK, BLK, BLK, BLK, S4, S2}, 1'b0, 21};
      vecs[4]  = '{"hex0lz",    20'h00000,   1'b0, 1'b1, {BLK, BLK, BLK, BLK, BLK, S0}, 1'b0, 0};
      vecs[5]  = '{"dec0",      20'd0,       1'b1, 1'b0, {S0, S0, S0, S0, S0, S0},     1'b0, 21};
      vecs[6]  = '{"hexFFFFF",  20'hFFFFF,   1'b0, 1'b0, {S0, SF, SF, SF, SF, SF},     1'b0, 0};
      vecs[7]  = '{"dec999999", 20'd999999,  1'b1, 1'b1, {S9, S9, S9, S9, S9, S9},     1'b0, 21};
      vecs[8]  = '{"hex00120lz",20'h00120,   1'b0, 1'b1, {BLK, BLK, BLK, S1, S2, S0},  1'b0, 0};
      vecs[9]  = '{"decMax",    20'd1048575, 1'b1, 1'b0, {DSH, DSH, DSH, DSH, DSH, DSH}, 1'b1, 21};
      vecs[10] = '{"dec100lz",  20'd100,     1'b1, 1'b1, {BLK, BLK, BLK, S1, S0, S0},  1'b0, 21};

      // Reset held for two edges, then the display must stay dark with no load
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset leds", 64'(leds), 64'(DARK));
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset ovf", 64'(ovf), 64'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("idle dark leds", 64'(leds), 64'(DARK));

      // Main table
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i]);
      end

      // Loads during SHIFT and during DONE must be ignored
      @(negedge clk);
      din = 20'd999999; decMode = 1'b1; lzBlank = 1'b0; load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      cyc = 1;
      while (busy === 1'b1 && cyc < 100) begin
         if (cyc == 5 || cyc == 21) begin
            din = 20'd7; decMode = 1'b0; load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      load = 1'b0;
      checkOutput("ignore busy cycles", 64'(cyc - 1), 64'd21);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ignore leds", 64'(leds), 64'({S9, S9, S9, S9, S9, S9}));
      checkOutput("ignore busy idle", 64'(busy), 64'd0);
      checkOutput("ignore ovf", 64'(ovf), 64'd0);

      // Reset mid-conversion aborts immediately, then a fresh conversion works
      @(negedge clk);
      din = 20'd123456; decMode = 1'b1; load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst leds", 64'(leds), 64'(DARK));
      checkOutput("midrst busy", 64'(busy), 64'd0);
      checkOutput("midrst ovf", 64'(ovf), 64'd0);
      prevExp = DARK;
      applyStimulus('{"postrst42", 20'd42, 1'b1, 1'b0, {S0, S0, S0, S0, S4, S2}, 1'b0, 21});

`ifdef SEG_BLINK_EN
      // Blink digit 0 on the value 12: digit 0 alternates every 4 cycles, others steady
      begin
         logic [6:0] last;
         logic [6:0] v0;
         logic [6:0] expD0;
         int         waitCyc;
         applyStimulus('{"blink12", 20'd12, 1'b1, 1'b1, {BLK, BLK, BLK, BLK, S1, S2}, 1'b0, 21});
         blink = 6'b000001;
         @(posedge clk);
         #1;
         last = leds[6:0];
         waitCyc = 0;
         while (leds[6:0] === last && waitCyc < 20) begin
            @(posedge clk);
            #1;
            waitCyc++;
         end
         checkOutput("blink toggle seen", 64'(waitCyc < 20), 64'd1);
         v0 = leds[6:0];
         checkOutput("blink phase value", 64'(v0 === S2 || v0 === BLK), 64'd1);
         for (int i = 1; i < 12; i++) begin
            @(posedge clk);
            #1;
            expD0 = (((i / 4) % 2) == 0) ? v0 : ((v0 === S2) ? BLK : S2);
            checkOutput("blink digit0", 64'(leds[6:0]), 64'(expD0));
            checkOutput("blink digit1", 64'(leds[13:7]), 64'(S1));
         end
         expC = {BLK, BLK, BLK, BLK, 14'h0};
         checkOutput("blink upper digits", 64'(leds[41:14]), 64'(expC[41:14]));
         blink = '0;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
